mux_pipeline_serializer: RTL and testbench

//  Parametrised successor of the 16-to-4 byte group mux. Captures one wide vector of LANES

---
 rtl/mux_pipeline_serializer.sv | 81 ++++++++
 tb/tb_mux_pipeline_serializer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_pipeline_serializer.sv
// Wide-vector to narrow-beat serializer: captures LANES lanes and emits GROUP lanes per beat,
// lane 0 first, with valid/ready on both sides and a per-vector group count.
module mux_pipeline_serializer #(
  parameter int DATA_W = 8,
  parameter int LANES  = 16,
  parameter int GROUP  = 4,
  localparam int NGRP  = LANES / GROUP,
  localparam int CW    = $clog2(NGRP + 1),
  localparam int IW    = (NGRP > 1) ? $clog2(NGRP) : 1,
  localparam int VW    = LANES * DATA_W,
  localparam int GW    = GROUP * DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [VW-1:0] in_data,
  input  logic [CW-1:0] in_groups,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [GW-1:0] out_data,
  output logic [IW-1:0] out_idx,
  output logic          out_last
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]    state;
  logic [VW-1:0] vec;
  logic [IW-1:0] g;
  logic [IW-1:0] last_idx;
  logic [CW-1:0] eff_groups;
  logic [IW-1:0] last_next;
  logic          accept;

  assign out_valid = (state == SEND);
  assign out_idx   = g;
  assign out_last  = out_valid && (g == last_idx);
  // in_ready depends on out_ready so a new vector can land on the last beat (no bubble)
  assign in_ready  = !rst && ((state == IDLE) || (out_valid && out_ready && out_last));
  assign accept    = in_valid && in_ready;

  // Out-of-range group counts (0 or above NGRP) mean "send the whole vector"
  always_comb begin
    eff_groups = in_groups;
    if (in_groups == '0 || in_groups > CW'(NGRP))
      eff_groups = CW'(NGRP);
    last_next = IW'(eff_groups - CW'(1));
  end

  always_comb begin
    out_data = '0;
    for (int unsigned i = 0; i < NGRP; i++) begin
      if (g == IW'(i))
        out_data = vec[VW - 1 - int'(i) * GW -: GW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      vec      <= '0;
      g        <= '0;
      last_idx <= '0;
    end else if (accept) begin
      state    <= SEND;
      vec      <= in_data;
      g        <= '0;
      last_idx <= last_next;
    end else if (state == SEND && out_ready) begin
      if (out_last) begin
        state <= IDLE;
        g     <= '0;
      end else begin
        g <= g + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mux_pipeline_serializer.sv
// Bench for mux_pipeline_serializer: a beat-queue model fed from input handshakes is checked
// every cycle, plus literal beat values for the directed cases and a second lane-width config.
module tb_mux_pipeline_serializer;

  logic         clk = 1'b0;
  logic         rst;
  logic         sel;
  logic         in_valid;
  logic [127:0] in_data;
  logic [2:0]   in_groups;
  logic         out_ready;

  logic        ir0, ov0, ol0, ir1, ov1, ol1;
  logic [31:0] od0, od1;
  logic [1:0]  oi0, oi1;

  logic        in_ready_m, out_valid_m, out_last_m;
  logic [31:0] out_data_m;
  logic [1:0]  out_idx_m;

  int n_cmp = 0;
  int n_bad = 0;

  logic [34:0] q[$];
  logic [31:0] log_q[$];

  always #5 clk = ~clk;

  mux_pipeline_serializer #(.DATA_W(8), .LANES(16), .GROUP(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid && !sel), .in_ready(ir0),
    .in_data(in_data), .in_groups(in_groups), .out_valid(ov0), .out_ready(out_ready),
    .out_data(od0), .out_idx(oi0), .out_last(ol0)
  );

  mux_pipeline_serializer #(.DATA_W(16), .LANES(8), .GROUP(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel), .in_ready(ir1),
    .in_data(in_data), .in_groups(in_groups), .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1), .out_idx(oi1), .out_last(ol1)
  );

  assign in_ready_m  = sel ? ir1 : ir0;
  assign out_valid_m = sel ? ov1 : ov0;
  assign out_last_m  = sel ? ol1 : ol0;
  assign out_data_m  = sel ? od1 : od0;
  assign out_idx_m   = sel ? oi1 : oi0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Beat g of a vector: lanes g*per..g*per+per-1 taken from the MSB-first lane layout.
  function automatic logic [31:0] beat(input logic [127:0] d, input int g, input int dw);
    logic [31:0]  r = '0;
    logic [127:0] lane;
    int per = 32 / dw;
    for (int j = 0; j < per; j++) begin
      int k = g * per + j;
      lane = (d >> (128 - (k + 1) * dw)) & ((128'd1 << dw) - 128'd1);
      r = (r << dw) | lane[31:0];
    end
    return r;
  endfunction

  function automatic logic [127:0] mkv(input int dw, input int base);
    logic [127:0] d = '0;
    for (int k = 0; k < 128 / dw; k++)
      d = (d << dw) | 128'(base + k);
    return d;
  endfunction

  always @(negedge clk) begin
    logic exp_v, exp_rdy;
    int   gcnt;
    if (rst) begin
      chk("rst_in_ready", 64'(in_ready_m), 64'(0));
      q.delete();
    end else begin
      exp_v = (q.size() > 0);
      exp_rdy = !exp_v || (out_ready && q[0][34]);
      chk("out_valid", 64'(out_valid_m), 64'(exp_v));
      chk("in_ready", 64'(in_ready_m), 64'(exp_rdy));
      if (exp_v) begin
        chk("beat", 64'({out_last_m, out_idx_m, out_data_m}), 64'(q[0]));
        if (out_ready) begin
          log_q.push_back(q[0][31:0]);
          void'(q.pop_front());
        end
      end
      if (in_valid && exp_rdy) begin
        gcnt = (in_groups == 0 || in_groups > 4) ? 4 : int'(in_groups);
        for (int g = 0; g < gcnt; g++)
          q.push_back({(g == gcnt - 1), 2'(g), beat(in_data, g, sel ? 16 : 8)});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] d, input logic [2:0] gs);
    int   n = 0;
    logic acc = 1'b0;
    in_valid  = 1'b1;
    in_data   = d;
    in_groups = gs;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready_m;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("send_timeout", 64'(0), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() > 0 || out_valid_m) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk("idle_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; sel = 1'b0; in_valid = 1'b0; in_data = '0; in_groups = '0; out_ready = 1'b1;
    tick();
    chk("reset_out_valid", 64'(out_valid_m), 64'(0));
    chk("reset_out_last", 64'(out_last_m), 64'(0));
    chk("reset_out_idx", 64'(out_idx_m), 64'(0));
    chk("reset_out_data", 64'(out_data_m), 64'(0));
    chk("reset_in_ready", 64'(in_ready_m), 64'(0));
    tick();
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", 64'(in_ready_m), 64'(1));

    // basic vector, full group count
    log_q.delete();
    send(mkv(8, 0), 3'd4);
    wait_idle();
    chk("t1_count", 64'(log_q.size()), 64'(4));
    if (log_q.size() == 4) begin
      chk("t1_b0", 64'(log_q[0]), 64'(32'h00010203));
      chk("t1_b1", 64'(log_q[1]), 64'(32'h04050607));
      chk("t1_b2", 64'(log_q[2]), 64'(32'h08090A0B));
      chk("t1_b3", 64'(log_q[3]), 64'(32'h0C0D0E0F));
    end

    // back-to-back vectors
    log_q.delete();
    send(mkv(8, 0), 3'd4);
    send(mkv(8, 16), 3'd4);
    wait_idle();
    chk("t2_count", 64'(log_q.size()), 64'(8));
    if (log_q.size() == 8) begin
      chk("t2_b3", 64'(log_q[3]), 64'(32'h0C0D0E0F));
      chk("t2_b4", 64'(log_q[4]), 64'(32'h10111213));
      chk("t2_b7", 64'(log_q[7]), 64'(32'h1C1D1E1F));
    end

    // stall pattern 1,0,0,1
    log_q.delete();
    send(mkv(8, 0), 3'd4);
    out_ready = 1'b1; tick();
    out_ready = 1'b0; tick();
    tick();
    out_ready = 1'b1;
    wait_idle();
    chk("t3_count", 64'(log_q.size()), 64'(4));
    if (log_q.size() == 4) begin
      chk("t3_b1", 64'(log_q[1]), 64'(32'h04050607));
      chk("t3_b2", 64'(log_q[2]), 64'(32'h08090A0B));
    end

    // short group count, then zero meaning all groups, then oversize
    log_q.delete();
    send(mkv(8, 0), 3'd2);
    wait_idle();
    chk("t4_count2", 64'(log_q.size()), 64'(2));
    if (log_q.size() == 2) begin
      chk("t4_b0", 64'(log_q[0]), 64'(32'h00010203));
      chk("t4_b1", 64'(log_q[1]), 64'(32'h04050607));
    end
    log_q.delete();
    send(mkv(8, 0), 3'd0);
    wait_idle();
    chk("t4_count0", 64'(log_q.size()), 64'(4));
    log_q.delete();
    send(mkv(8, 32), 3'd7);
    wait_idle();
    chk("t4_count7", 64'(log_q.size()), 64'(4));
    log_q.delete();
    send(mkv(8, 48), 3'd1);
    wait_idle();
    chk("t4_count1", 64'(log_q.size()), 64'(1));

    // reset mid-vector
    send(mkv(8, 0), 3'd4);
    n = 0;
    while (out_idx_m != 2'd2 && n < 50) begin
      tick();
      n++;
    end
    chk("t5_reached_idx2", 64'(out_idx_m), 64'(2));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t5_out_valid_after_rst", 64'(out_valid_m), 64'(0));
    log_q.delete();
    send(mkv(8, 0), 3'd4);
    chk("t5_first_idx", 64'(out_idx_m), 64'(0));
    wait_idle();
    chk("t5_count", 64'(log_q.size()), 64'(4));
    if (log_q.size() == 4)
      chk("t5_b0", 64'(log_q[0]), 64'(32'h00010203));

    // 16-bit lanes, 8 lanes, 2 per beat
    sel = 1'b1;
    tick();
    log_q.delete();
    send(mkv(16, 16'hA000), 3'd4);
    wait_idle();
    chk("t6_count", 64'(log_q.size()), 64'(4));
    if (log_q.size() == 4) begin
      chk("t6_b0", 64'(log_q[0]), 64'(32'hA000A001));
      chk("t6_b3", 64'(log_q[3]), 64'(32'hA006A007));
    end
    log_q.delete();
    send(mkv(16, 16'h1230), 3'd3);
    out_ready = 1'b0; tick();
    out_ready = 1'b1;
    wait_idle();
    chk("t6_count3", 64'(log_q.size()), 64'(3));
    if (log_q.size() == 3)
      chk("t6_b2", 64'(log_q[2]), 64'(32'h12341235));

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
